rs232in_fifo: RTL

//  Receive buffer between rs232in (byte + 1-cycle attention pulse) and the rs232 peripheral

---
 rtl/rs232in_fifo_pkg.sv | 31 +++
 rtl/fifo_mem8.sv | 24 ++
 rtl/rs232in_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/rs232in_fifo_pkg.sv
// rtl/rs232in_fifo_pkg.sv - shared rs232 peripheral constants and FIFO operation encoding
package rs232in_fifo_pkg;

    // Register offsets of the rs232 peripheral block
    typedef enum logic [1:0] {
        RS232_OFS_OUT_BUSY = 2'd0,
        RS232_OFS_IN_DATA  = 2'd1,
        RS232_OFS_IN_COUNT = 2'd2,
        RS232_OFS_TSC      = 2'd3
    } rs232_ofs_e;

    // Per-cycle FIFO operation, encoded as {pop, push}
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    localparam int DEPTH_LOG2_MIN = 2;
    localparam int DEPTH_LOG2_MAX = 10;

    // IN_COUNT read word: {overrun, count}, count sized for the largest legal depth
    function automatic logic [DEPTH_LOG2_MAX+1:0] in_count_status(
        input logic                    ovr,
        input logic [DEPTH_LOG2_MAX:0] cnt
    );
        return {ovr, cnt};
    endfunction

endpackage

// File: rtl/fifo_mem8.sv
// rtl/fifo_mem8.sv - depth x 8 register file, one synchronous write port, one asynchronous read port
module fifo_mem8 #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**DEPTH_LOG2];

    // Storage is deliberately not reset; the head is only meaningful while non-empty
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rs232in_fifo.sv
// rtl/rs232in_fifo.sv - rs232 receive FIFO with sticky overrun; RS232IN_FIFO_RTS_EN enables nrts hysteresis
module rs232in_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_HIGH   = 12,
    parameter int RTS_LOW    = 4
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                in_attention,
    input  logic [7:0]          in_data,
    input  logic                rd,
    output logic [7:0]          rd_data,
    output logic [DEPTH_LOG2:0] count,
    output logic                empty,
    output logic                full,
    output logic                overrun,
    input  logic                clr_overrun,
    output logic                nrts
);

    import rs232in_fifo_pkg::*;

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  push;
    logic                  pop;
    logic                  drop;
    fifo_op_e              op;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it
    assign pop  = rd & ~empty;
    assign push = in_attention & (~full | pop);
    assign drop = in_attention & full & ~pop;
    assign op   = fifo_op_e'({pop, push});

    // Next occupancy; push and pop together leave it unchanged
    always_comb begin
        count_next = count;
        case (op)
            FIFO_PUSH: count_next = count + 1'b1;
            FIFO_POP:  count_next = count - 1'b1;
            default:   count_next = count;
        endcase
    end

    // Pointers, occupancy, registered flags and the sticky overrun
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_COUNT);
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    fifo_mem8 #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

`ifdef RS232IN_FIFO_RTS_EN
    localparam logic [DEPTH_LOG2:0] RTS_HIGH_C = (DEPTH_LOG2+1)'(RTS_HIGH);
    localparam logic [DEPTH_LOG2:0] RTS_LOW_C  = (DEPTH_LOG2+1)'(RTS_LOW);

    // Flow control with hysteresis, evaluated on the post-edge occupancy
    always_ff @(posedge clock) begin
        if (rst) begin
            nrts <= 1'b0;
        end else if (count_next >= RTS_HIGH_C) begin
            nrts <= 1'b1;
        end else if (count_next <= RTS_LOW_C) begin
            nrts <= 1'b0;
        end
    end
`else
    assign nrts = 1'b0;
`endif

endmodule
